// File: rtl/pe_pkg.sv
// Shared PE definitions: opcode encoding and default datapath geometry.
// Imported by the fetch unit and the execution unit.
package pe_pkg;

  localparam int PE_DEF_DATA_LEN    = 32;
  localparam int PE_DEF_ELEMENTS    = 4;
  localparam int PE_DEF_OPCODE_LEN  = 4;

  typedef enum logic [3:0] {
    PE_NOP           = 4'd0,
    PE_ADD           = 4'd1,
    PE_SUB           = 4'd2,
    PE_MUL           = 4'd3,
    PE_DOTP          = 4'd4,
    PE_STORE_TEMP_S1 = 4'd5,
    PE_STORE_TEMP_S2 = 4'd6,
    PE_STORE_RESULT  = 4'd7,
    PE_STOP          = 4'd8
  } pe_op_e;

  typedef enum logic [1:0] {
    LANE_ADD = 2'd0,
    LANE_SUB = 2'd1,
    LANE_MUL = 2'd2
  } lane_op_e;

endpackage

// File: rtl/pe_lane.sv
// One lane of the element-wise datapath; prod is always a*b so the
// dot-product path can share the lane multiplier.
module pe_lane
  import pe_pkg::*;
#(
  parameter int DATA_LEN = PE_DEF_DATA_LEN
) (
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  input  lane_op_e            op,
  output logic [DATA_LEN-1:0] res,
  output logic [DATA_LEN-1:0] prod
);

  assign prod = a * b;

  always_comb begin
    res = prod;
    case (op)
      LANE_ADD: res = a + b;
      LANE_SUB: res = a - b;
      default:  res = prod;
    endcase
  end

endmodule

// File: rtl/pe_exec_unit.sv
// PE execution unit: operand registers, element-wise ops into S1, a
// two-stage dot product into S2, and store pulses for S1/S2.
module pe_exec_unit
  import pe_pkg::*;
#(
  parameter int DATA_LEN      = PE_DEF_DATA_LEN,
  parameter int PE_ELEMENTS   = PE_DEF_ELEMENTS,
  parameter int PE_OPCODE_LEN = PE_DEF_OPCODE_LEN
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  load_a,
  input  logic                                  load_b,
  input  logic [PE_OPCODE_LEN-1:0]              pe_opcode,
  input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]  data_a,
  input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]  data_b,
  output logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]  pe_stage_1_output,
  output logic                                  pe_stage_1_valid,
  output logic [DATA_LEN-1:0]                   pe_stage_2_output,
  output logic                                  pe_stage_2_valid,
  output logic                                  busy
);

  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0] a_q, b_q, s1_q, prod_q;
  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0] lane_res, lane_prod;
  logic [DATA_LEN-1:0]                  s2_q, dot_sum;
  logic                                 prod_vld, pending;
  lane_op_e                             lane_op;

  logic is_add, is_sub, is_mul, is_dotp, is_st1, is_st2, is_stop, is_arith;
  assign is_add   = (pe_opcode == PE_OPCODE_LEN'(PE_ADD));
  assign is_sub   = (pe_opcode == PE_OPCODE_LEN'(PE_SUB));
  assign is_mul   = (pe_opcode == PE_OPCODE_LEN'(PE_MUL));
  assign is_dotp  = (pe_opcode == PE_OPCODE_LEN'(PE_DOTP));
  assign is_st1   = (pe_opcode == PE_OPCODE_LEN'(PE_STORE_TEMP_S1));
  assign is_st2   = (pe_opcode == PE_OPCODE_LEN'(PE_STORE_TEMP_S2));
  assign is_stop  = (pe_opcode == PE_OPCODE_LEN'(PE_STOP));
  assign is_arith = is_add | is_sub | is_mul;

  always_comb begin
    lane_op = LANE_MUL;
    if (is_add)      lane_op = LANE_ADD;
    else if (is_sub) lane_op = LANE_SUB;
  end

  for (genvar i = 0; i < PE_ELEMENTS; i++) begin : g_lane
    pe_lane #(.DATA_LEN(DATA_LEN)) u_lane (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .op   (lane_op),
      .res  (lane_res[i]),
      .prod (lane_prod[i])
    );
  end

  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < PE_ELEMENTS; i++) dot_sum = dot_sum + prod_q[i];
  end

  assign busy = prod_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q               <= '0;
      b_q               <= '0;
      s1_q              <= '0;
      s2_q              <= '0;
      prod_q            <= '0;
      prod_vld          <= 1'b0;
      pending           <= 1'b0;
      pe_stage_1_output <= '0;
      pe_stage_1_valid  <= 1'b0;
      pe_stage_2_output <= '0;
      pe_stage_2_valid  <= 1'b0;
    end else begin
      if (load_a) a_q <= data_a;
      if (load_b) b_q <= data_b;
      pe_stage_1_valid <= 1'b0;
      pe_stage_2_valid <= 1'b0;
      if (is_stop) begin
        // The sum in flight is dropped: S2 is not written this edge.
        prod_vld <= 1'b0;
        pending  <= 1'b0;
      end else begin
        prod_vld <= is_dotp;
        if (is_arith) s1_q   <= lane_res;
        if (is_dotp)  prod_q <= lane_prod;
        if (prod_vld) s2_q   <= dot_sum;
        if (is_st1) begin
          pe_stage_1_output <= s1_q;
          pe_stage_1_valid  <= 1'b1;
        end
        // A pending store fires one cycle after the in-flight sum landed in S2.
        if (pending || (is_st2 && !prod_vld)) begin
          pe_stage_2_output <= s2_q;
          pe_stage_2_valid  <= 1'b1;
        end
        pending <= is_st2 && prod_vld;
      end
    end
  end

endmodule

// File: tb/tb_pe_exec_unit.sv
// Directed bench for pe_exec_unit: per-cycle vector table plus hand
// sequences for STOP cancellation and asynchronous reset.
module tb_pe_exec_unit;
  import pe_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         load_a = 1'b0, load_b = 1'b0;
  logic [3:0]   pe_opcode = 4'd0;
  logic [3:0][31:0] data_a = '0, data_b = '0;
  logic [3:0][31:0] pe_stage_1_output;
  logic         pe_stage_1_valid;
  logic [31:0]  pe_stage_2_output;
  logic         pe_stage_2_valid;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  pe_exec_unit #(.DATA_LEN(32), .PE_ELEMENTS(4), .PE_OPCODE_LEN(4)) dut (
    .clk(clk), .rstn(rstn), .load_a(load_a), .load_b(load_b),
    .pe_opcode(pe_opcode), .data_a(data_a), .data_b(data_b),
    .pe_stage_1_output(pe_stage_1_output), .pe_stage_1_valid(pe_stage_1_valid),
    .pe_stage_2_output(pe_stage_2_output), .pe_stage_2_valid(pe_stage_2_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         la, lb;
    logic [3:0]   op;
    logic [127:0] da, db;
    logic [127:0] e1;
    logic         ev1;
    logic [31:0]  e2;
    logic         ev2, ebusy;
  } vec_t;

  vec_t rows[30];

  function automatic logic [127:0] v4(input int unsigned x0, x1, x2, x3);
    return {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
  endfunction

  function automatic vec_t mk(input logic la, lb, input logic [3:0] op,
                              input logic [127:0] da, db, e1, input logic ev1,
                              input logic [31:0] e2, input logic ev2, ebusy);
    vec_t r;
    r.la = la; r.lb = lb; r.op = op; r.da = da; r.db = db;
    r.e1 = e1; r.ev1 = ev1; r.e2 = e2; r.ev2 = ev2; r.ebusy = ebusy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [127:0] e1, input logic ev1,
                         input logic [31:0] e2, input logic ev2, ebusy);
    chk({tag, ".out1"}, pe_stage_1_output, e1);
    chk({tag, ".v1"},   128'(pe_stage_1_valid), 128'(ev1));
    chk({tag, ".out2"}, 128'(pe_stage_2_output), 128'(e2));
    chk({tag, ".v2"},   128'(pe_stage_2_valid), 128'(ev2));
    chk({tag, ".busy"}, 128'(busy), 128'(ebusy));
  endtask

  // Inputs applied at a falling edge hold for the following rising edge.
  task automatic tick(input logic la, lb, input logic [3:0] op,
                      input logic [127:0] da, db);
    @(negedge clk);
    load_a = la; load_b = lb; pe_opcode = op; data_a = da; data_b = db;
  endtask

  logic [127:0] Z, A1, B1, E_ADD1, E_MUL1, A2, E_ADD2, ONES, E_SUB, AM, BM, E_MUL, B5, BO, BT, B3;
  logic [3:0] NOP, ADD, SUB, MUL, DOT, ST1, ST2, SRES, STP;

  initial begin
    Z = '0;
    A1 = v4(1,2,3,4); B1 = v4(10,20,30,40); E_ADD1 = v4(11,22,33,44);
    E_MUL1 = v4(10,40,90,160);
    A2 = v4(100,200,300,400); E_ADD2 = v4(110,220,330,440);
    ONES = v4(1,1,1,1); E_SUB = {4{32'hFFFF_FFFF}};
    AM = v4(32'h10000,2,3,4); BM = v4(32'h10000,5,6,7); E_MUL = v4(0,10,18,28);
    B5 = v4(5,6,7,8); BO = ONES; BT = v4(2,2,2,2); B3 = v4(3,3,3,3);
    NOP = 4'(PE_NOP); ADD = 4'(PE_ADD); SUB = 4'(PE_SUB); MUL = 4'(PE_MUL);
    DOT = 4'(PE_DOTP); ST1 = 4'(PE_STORE_TEMP_S1); ST2 = 4'(PE_STORE_TEMP_S2);
    SRES = 4'(PE_STORE_RESULT); STP = 4'(PE_STOP);

    //           la lb op    da    db    out1    v1 out2 v2 busy
    rows[0]  = mk(1, 1, NOP, A1,   B1,   Z,      0, 0,  0, 0);
    rows[1]  = mk(0, 0, ADD, Z,    Z,    Z,      0, 0,  0, 0);
    rows[2]  = mk(0, 0, ST1, Z,    Z,    Z,      0, 0,  0, 0);
    rows[3]  = mk(0, 0, NOP, Z,    Z,    E_ADD1, 1, 0,  0, 0);
    rows[4]  = mk(0, 0, MUL, Z,    Z,    E_ADD1, 0, 0,  0, 0);
    rows[5]  = mk(1, 0, ADD, A2,   Z,    E_ADD1, 0, 0,  0, 0);
    rows[6]  = mk(0, 0, ST1, Z,    Z,    E_ADD1, 0, 0,  0, 0);
    rows[7]  = mk(0, 0, ADD, Z,    Z,    E_ADD1, 1, 0,  0, 0);
    rows[8]  = mk(0, 0, ST1, Z,    Z,    E_ADD1, 0, 0,  0, 0);
    rows[9]  = mk(0, 0, NOP, Z,    Z,    E_ADD2, 1, 0,  0, 0);
    rows[10] = mk(1, 1, NOP, Z,    ONES, E_ADD2, 0, 0,  0, 0);
    rows[11] = mk(0, 0, SUB, Z,    Z,    E_ADD2, 0, 0,  0, 0);
    rows[12] = mk(0, 0, ST1, Z,    Z,    E_ADD2, 0, 0,  0, 0);
    rows[13] = mk(1, 1, NOP, AM,   BM,   E_SUB,  1, 0,  0, 0);
    rows[14] = mk(0, 0, MUL, Z,    Z,    E_SUB,  0, 0,  0, 0);
    rows[15] = mk(0, 0, ST1, Z,    Z,    E_SUB,  0, 0,  0, 0);
    rows[16] = mk(1, 1, NOP, A1,   B5,   E_MUL,  1, 0,  0, 0);
    rows[17] = mk(0, 0, DOT, Z,    Z,    E_MUL,  0, 0,  0, 0);
    rows[18] = mk(0, 0, ST2, Z,    Z,    E_MUL,  0, 0,  0, 1);
    rows[19] = mk(0, 0, NOP, Z,    Z,    E_MUL,  0, 0,  0, 0);
    rows[20] = mk(0, 0, NOP, Z,    Z,    E_MUL,  0, 70, 1, 0);
    rows[21] = mk(0, 1, ST2, Z,    BO,   E_MUL,  0, 70, 0, 0);
    rows[22] = mk(0, 1, DOT, Z,    BT,   E_MUL,  0, 70, 1, 0);
    rows[23] = mk(0, 0, DOT, Z,    Z,    E_MUL,  0, 70, 0, 1);
    rows[24] = mk(0, 0, ST2, Z,    Z,    E_MUL,  0, 70, 0, 1);
    rows[25] = mk(0, 0, NOP, Z,    Z,    E_MUL,  0, 70, 0, 0);
    rows[26] = mk(0, 0, SRES, Z,   Z,    E_MUL,  0, 20, 1, 0);
    rows[27] = mk(0, 0, 4'd12, Z,  Z,    E_MUL,  0, 20, 0, 0);
    rows[28] = mk(0, 0, ST1, Z,    Z,    E_MUL,  0, 20, 0, 0);
    rows[29] = mk(0, 0, NOP, Z,    Z,    E_MUL,  1, 20, 0, 0);

    #12;
    chk_all("reset", Z, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      tick(rows[i].la, rows[i].lb, rows[i].op, rows[i].da, rows[i].db);
      chk_all($sformatf("row%0d", i), rows[i].e1, rows[i].ev1, rows[i].e2,
              rows[i].ev2, rows[i].ebusy);
    end

    // STOP right after DOTP: S2 keeps 20, a later store shows the old value.
    tick(0, 1, NOP, Z, B3);
    tick(0, 0, DOT, Z, Z);
    tick(0, 0, STP, Z, Z);  chk_all("stop.t1", E_MUL, 0, 20, 0, 1);
    tick(0, 0, ST2, Z, Z);  chk_all("stop.t2", E_MUL, 0, 20, 0, 0);
    tick(0, 0, NOP, Z, Z);  chk_all("stop.t3", E_MUL, 0, 20, 1, 0);
    // STOP after a pending store: sum lands, pulse is cancelled.
    tick(0, 0, DOT, Z, Z);  chk_all("stpp.u0", E_MUL, 0, 20, 0, 0);
    tick(0, 0, ST2, Z, Z);  chk_all("stpp.u1", E_MUL, 0, 20, 0, 1);
    tick(0, 0, STP, Z, Z);  chk_all("stpp.u2", E_MUL, 0, 20, 0, 0);
    tick(0, 0, NOP, Z, Z);  chk_all("stpp.u3", E_MUL, 0, 20, 0, 0);
    tick(0, 0, ST2, Z, Z);  chk_all("stpp.u4", E_MUL, 0, 20, 0, 0);
    tick(0, 0, NOP, Z, Z);  chk_all("stpp.u5", E_MUL, 0, 30, 1, 0);

    // Asynchronous reset in the middle of a DOTP.
    tick(0, 0, DOT, Z, Z);
    tick(0, 0, NOP, Z, Z);  chk_all("rst.busy", E_MUL, 0, 30, 0, 1);
    #2 rstn = 1'b0;
    #1 chk_all("rst.async", Z, 0, 0, 0, 0);
    tick(0, 0, ST2, Z, Z);
    tick(0, 0, NOP, Z, Z);
    rstn = 1'b1;
    tick(0, 0, NOP, Z, Z);  chk_all("rst.rel1", Z, 0, 0, 0, 0);
    tick(0, 0, NOP, Z, Z);  chk_all("rst.rel2", Z, 0, 0, 0, 0);

    // First opcode after release is taken on the first rising edge.
    #2 rstn = 1'b0;
    tick(0, 0, ST2, Z, Z);
    rstn = 1'b1;
    tick(0, 0, NOP, Z, Z);  chk_all("rst.first", Z, 0, 0, 1, 0);
    tick(0, 0, NOP, Z, Z);  chk_all("rst.after", Z, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
